// File: rtl/mp3_pkg.sv
// mp3_pkg: shared state encoding and SCI constants for the VS1003 bus scheduler.
package mp3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_SCI_ISSUE,
        ST_SCI_WAIT,
        ST_RST_DREQ,
        ST_SDI_ISSUE,
        ST_SDI_WAIT
    } state_t;

    localparam logic [7:0]  SCI_WRITE_OP = 8'h02;
    localparam logic [7:0]  MODE_ADDR    = 8'h00;
    localparam logic [15:0] MUTE_VOL     = 16'hFEFE;
    localparam logic [15:0] DEFAULT_VOL  = 16'h2020;

    function automatic logic [31:0] sci_word(
        input logic [7:0]  addr,
        input logic [15:0] data
    );
        return {SCI_WRITE_OP, addr, data};
    endfunction

endpackage

// File: rtl/mp3_req_latch.sv
// mp3_req_latch: pending flags and operand capture for volume and track-change requests.
// With MP3_PAUSE_MUTE_EN, pause edges also schedule mute/restore volume writes.
module mp3_req_latch
    import mp3_pkg::*;
(
    input  logic        MP3_SCLK,
    input  logic        RESET,
    input  logic        vol_req,
    input  logic [15:0] vol_value,
    input  logic        next_req,
`ifdef MP3_PAUSE_MUTE_EN
    input  logic        susp,
`endif
    input  logic        clr_vol,
    input  logic        clr_rst,
    output logic        vol_pend,
    output logic [15:0] vol_word,
    output logic        rst_pend
);

`ifdef MP3_PAUSE_MUTE_EN
    logic        susp_q;
    logic [15:0] last_vol;
`endif

    // A new request in the same cycle as a grant wins over the clear.
    always_ff @(posedge MP3_SCLK) begin
        if (RESET) begin
            vol_pend <= 1'b0;
            vol_word <= '0;
            rst_pend <= 1'b0;
`ifdef MP3_PAUSE_MUTE_EN
            susp_q   <= 1'b0;
            last_vol <= DEFAULT_VOL;
`endif
        end else begin
            if (clr_rst)
                rst_pend <= 1'b0;
            if (next_req)
                rst_pend <= 1'b1;
            if (clr_vol)
                vol_pend <= 1'b0;
`ifdef MP3_PAUSE_MUTE_EN
            susp_q <= susp;
            if (susp && !susp_q) begin
                vol_pend <= 1'b1;
                vol_word <= MUTE_VOL;
            end else if (!susp && susp_q) begin
                vol_pend <= 1'b1;
                vol_word <= last_vol;
            end
`endif
            if (vol_req) begin
                vol_pend <= 1'b1;
                vol_word <= vol_value;
`ifdef MP3_PAUSE_MUTE_EN
                last_vol <= vol_value;
`endif
            end
        end
    end

endmodule

// File: rtl/mp3_bus_sched.sv
// mp3_bus_sched: VS1003 SPI transaction scheduler (soft reset, SCI volume, SDI bursts).
// Optional MP3_PAUSE_MUTE_EN: mute/restore volume writes on pause edges.
module mp3_bus_sched
    import mp3_pkg::*;
#(
    parameter int          BURST_LEN     = 32,
    parameter logic [7:0]  VOL_ADDR      = 8'h0B,
    parameter logic [15:0] MODE_RST_WORD = 16'h0804
) (
    input  logic        MP3_SCLK,
    input  logic        RESET,
    input  logic        IS_SUSPENDING,
    input  logic        DREQ,
    input  logic        VOL_REQ,
    input  logic [15:0] VOL_VALUE,
    input  logic        NEXT_REQ,
    input  logic        DATA_VALID,
    input  logic [7:0]  DATA_BYTE,
    output logic        DATA_TAKE,
    output logic        TRACK_NEXT,
    output logic        SPI_START,
    output logic        SPI_SCI,
    output logic [31:0] SPI_WORD,
    output logic [5:0]  SPI_BITS,
    input  logic        SPI_DONE,
    output logic        BUSY
);

    localparam int            CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] BL = CW'(BURST_LEN);

    state_t        state;
    logic [CW-1:0] burst_cnt;
    logic          sci_rst;
    logic          dreq_q;
    logic          seen_hi;
    logic          trk;

    logic          vol_pend;
    logic [15:0]   vol_word;
    logic          rst_pend;

    logic          burst_open;
    logic          arb_pt;
    logic          g_rst;
    logic          g_vol;
    logic          g_dat;

    mp3_req_latch u_req (
        .MP3_SCLK  (MP3_SCLK),
        .RESET     (RESET),
        .vol_req   (VOL_REQ),
        .vol_value (VOL_VALUE),
        .next_req  (NEXT_REQ),
`ifdef MP3_PAUSE_MUTE_EN
        .susp      (IS_SUSPENDING),
`endif
        .clr_vol   (arb_pt && g_vol),
        .clr_rst   (arb_pt && g_rst),
        .vol_pend  (vol_pend),
        .vol_word  (vol_word),
        .rst_pend  (rst_pend)
    );

    // A pending track change closes the burst so the reset write can go next.
    assign burst_open = (burst_cnt != '0) && (burst_cnt != BL) && !rst_pend;

    assign g_rst = rst_pend && DREQ;
    assign g_vol = !rst_pend && vol_pend && DREQ && !burst_open;
    assign g_dat = !rst_pend && !g_vol && DATA_VALID
                 && (burst_open || (DREQ && !IS_SUSPENDING));

    assign arb_pt = (state == ST_IDLE) || (state == ST_ARB)
                 || ((state == ST_SDI_WAIT) && SPI_DONE)
                 || ((state == ST_SCI_WAIT) && SPI_DONE && !sci_rst);

    always_ff @(posedge MP3_SCLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            sci_rst   <= 1'b0;
            dreq_q    <= 1'b0;
            seen_hi   <= 1'b0;
            trk       <= 1'b0;
            SPI_SCI   <= 1'b0;
            SPI_WORD  <= '0;
            SPI_BITS  <= '0;
        end else begin
            dreq_q <= DREQ;
            trk    <= 1'b0;
            unique case (state)
                ST_SCI_ISSUE: state <= ST_SCI_WAIT;
                ST_SDI_ISSUE: state <= ST_SDI_WAIT;
                ST_SCI_WAIT: begin
                    if (SPI_DONE && sci_rst) begin
                        state   <= ST_RST_DREQ;
                        seen_hi <= 1'b0;
                    end
                end
                // Leave on a DREQ rising edge or two high samples in a row.
                ST_RST_DREQ: begin
                    seen_hi <= DREQ;
                    if (DREQ && (!dreq_q || seen_hi)) begin
                        trk       <= 1'b1;
                        burst_cnt <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: ;
            endcase
            if (arb_pt) begin
                if (g_rst) begin
                    state     <= ST_SCI_ISSUE;
                    sci_rst   <= 1'b1;
                    burst_cnt <= '0;
                    SPI_SCI   <= 1'b1;
                    SPI_BITS  <= 6'd32;
                    SPI_WORD  <= sci_word(MODE_ADDR, MODE_RST_WORD);
                end else if (g_vol) begin
                    state    <= ST_SCI_ISSUE;
                    sci_rst  <= 1'b0;
                    SPI_SCI  <= 1'b1;
                    SPI_BITS <= 6'd32;
                    SPI_WORD <= sci_word(VOL_ADDR, vol_word);
                end else if (g_dat) begin
                    state     <= ST_SDI_ISSUE;
                    burst_cnt <= burst_open ? burst_cnt + CW'(1) : CW'(1);
                    SPI_SCI   <= 1'b0;
                    SPI_BITS  <= 6'd8;
                    SPI_WORD  <= {24'h0, DATA_BYTE};
                end else begin
                    state <= burst_open ? ST_ARB : ST_IDLE;
                end
            end
        end
    end

    assign SPI_START  = (state == ST_SCI_ISSUE) || (state == ST_SDI_ISSUE);
    assign DATA_TAKE  = (state == ST_SDI_ISSUE);
    assign TRACK_NEXT = trk;
    assign BUSY       = ((state != ST_IDLE) && (state != ST_ARB)) || rst_pend;

endmodule

// File: tb/tb_mp3_bus_sched.sv
// tb_mp3_bus_sched: cycle table plus scoreboarded burst, pause, track-change
// and reset-abort sequences for mp3_bus_sched.
module tb_mp3_bus_sched;

    logic        MP3_SCLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IS_SUSPENDING = 1'b0;
    logic        DREQ = 1'b0;
    logic        VOL_REQ = 1'b0;
    logic [15:0] VOL_VALUE = '0;
    logic        NEXT_REQ = 1'b0;
    logic        DATA_VALID = 1'b0;
    logic [7:0]  DATA_BYTE = '0;
    logic        SPI_DONE = 1'b0;
    logic        DATA_TAKE, TRACK_NEXT, SPI_START, SPI_SCI, BUSY;
    logic [31:0] SPI_WORD;
    logic [5:0]  SPI_BITS;

    always #5 MP3_SCLK = ~MP3_SCLK;

    mp3_bus_sched dut (
        .MP3_SCLK      (MP3_SCLK),
        .RESET         (RESET),
        .IS_SUSPENDING (IS_SUSPENDING),
        .DREQ          (DREQ),
        .VOL_REQ       (VOL_REQ),
        .VOL_VALUE     (VOL_VALUE),
        .NEXT_REQ      (NEXT_REQ),
        .DATA_VALID    (DATA_VALID),
        .DATA_BYTE     (DATA_BYTE),
        .DATA_TAKE     (DATA_TAKE),
        .TRACK_NEXT    (TRACK_NEXT),
        .SPI_START     (SPI_START),
        .SPI_SCI       (SPI_SCI),
        .SPI_WORD      (SPI_WORD),
        .SPI_BITS      (SPI_BITS),
        .SPI_DONE      (SPI_DONE),
        .BUSY          (BUSY)
    );

`ifdef MP3_PAUSE_MUTE_EN
    localparam int MUTE_N = 1;
`else
    localparam int MUTE_N = 0;
`endif

    typedef struct {
        logic        rst, dreq, vreq;
        logic [15:0] vval;
        logic        nreq, done;
        logic        start, sci;
        logic [31:0] word;
        logic [5:0]  bits;
        logic        take, busy, trk;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    int nvec = 0;
    int errs = 0;
    int takes = 0, sci_starts = 0, sdi_starts = 0, trk_cnt = 0;
    int timer = 0;
    logic auto_spi = 1'b0, sb_en = 1'b0, rd_en = 1'b0;
    logic prev_take = 1'b0, prev_start = 1'b0;
    logic [31:0] cap_word;
    logic [6:0]  cap_cfg;
    logic [31:0] sci_q [$];
    logic [31:0] sdi_q [$];
    logic [7:0]  rd_byte;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input logic sci);
        logic [31:0] e;
        nvec++;
        if ((sci && sci_q.size() == 0) || (!sci && sdi_q.size() == 0)) begin
            errs++;
            $display("FAIL unexpected_start: sci=%0b word %h with empty queue", sci, SPI_WORD);
        end else begin
            e = sci ? sci_q.pop_front() : sdi_q.pop_front();
            nvec--;
            chk(sci ? "sci_word" : "sdi_word", SPI_WORD, e);
            chk("bits", SPI_BITS, sci ? 32 : 8);
        end
    endtask

    // One clock: reader, SPI engine model, scoreboard and protocol checks.
    task automatic step();
        @(posedge MP3_SCLK);
        #1;
        if (rd_en && prev_take) begin
            rd_byte   = rd_byte + 8'd1;
            DATA_BYTE = rd_byte;
            if (sb_en) sdi_q.push_back({24'h0, rd_byte});
        end
        if (prev_start) chk("start_gap", SPI_START, 0);
        if (DATA_TAKE) takes++;
        if (TRACK_NEXT) trk_cnt++;
        if (auto_spi) begin
            SPI_DONE = 1'b0;
            if (timer > 0) begin
                chk("hold_word", SPI_WORD, cap_word);
                chk("hold_cfg", {SPI_SCI, SPI_BITS}, cap_cfg);
                timer--;
                if (timer == 0) SPI_DONE = 1'b1;
            end
        end
        if (SPI_START) begin
            cap_word = SPI_WORD;
            cap_cfg  = {SPI_SCI, SPI_BITS};
            if (SPI_SCI) sci_starts++;
            else sdi_starts++;
            if (sb_en) pop_chk(SPI_SCI);
            if (auto_spi) timer = 4;
        end
        prev_take  = DATA_TAKE;
        prev_start = SPI_START;
    endtask

    task automatic vol(input logic [15:0] v);
        VOL_REQ   = 1'b1;
        VOL_VALUE = v;
        if (sb_en) sci_q.push_back({8'h02, 8'h0B, v});
        step();
        VOL_REQ = 1'b0;
    endtask

    initial begin
        int s0, t0, k0;
        //         rst dreq vreq vval      nreq done st sci word          bits  tk bsy trk
        tbl[0]  = '{1, 1, 0, 16'h0000, 0, 0, 0, 0, 32'h00000000, 6'd0,  0, 0, 0};
        tbl[1]  = '{0, 1, 1, 16'h1010, 0, 0, 0, 0, 32'h00000000, 6'd0,  0, 0, 0};
        tbl[2]  = '{0, 1, 0, 16'h0000, 0, 0, 1, 1, 32'h020B1010, 6'd32, 0, 1, 0};
        tbl[3]  = '{0, 1, 0, 16'h0000, 0, 0, 0, 1, 32'h020B1010, 6'd32, 0, 1, 0};
        tbl[4]  = '{0, 1, 0, 16'h0000, 0, 1, 0, 1, 32'h020B1010, 6'd32, 0, 0, 0};
        tbl[5]  = '{1, 1, 0, 16'h0000, 0, 0, 0, 0, 32'h00000000, 6'd0,  0, 0, 0};
        tbl[6]  = '{0, 0, 0, 16'h0000, 1, 0, 0, 0, 32'h00000000, 6'd0,  0, 1, 0};
        tbl[7]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 32'h00000000, 6'd0,  0, 1, 0};
        tbl[8]  = '{0, 1, 0, 16'h0000, 0, 0, 1, 1, 32'h02000804, 6'd32, 0, 1, 0};
        tbl[9]  = '{0, 1, 0, 16'h0000, 0, 0, 0, 1, 32'h02000804, 6'd32, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 16'h0000, 0, 1, 0, 1, 32'h02000804, 6'd32, 0, 1, 0};
        tbl[11] = '{0, 0, 0, 16'h0000, 0, 0, 0, 1, 32'h02000804, 6'd32, 0, 1, 0};
        tbl[12] = '{0, 1, 0, 16'h0000, 0, 0, 0, 1, 32'h02000804, 6'd32, 0, 0, 1};
        tbl[13] = '{0, 1, 0, 16'h0000, 0, 0, 0, 1, 32'h02000804, 6'd32, 0, 0, 0};
        tbl[14] = '{0, 1, 1, 16'h3344, 1, 0, 0, 1, 32'h02000804, 6'd32, 0, 1, 0};
        tbl[15] = '{0, 1, 0, 16'h0000, 0, 0, 1, 1, 32'h02000804, 6'd32, 0, 1, 0};
        tbl[16] = '{0, 1, 0, 16'h0000, 0, 0, 0, 1, 32'h02000804, 6'd32, 0, 1, 0};
        tbl[17] = '{0, 1, 0, 16'h0000, 0, 1, 0, 1, 32'h02000804, 6'd32, 0, 1, 0};
        tbl[18] = '{0, 1, 0, 16'h0000, 0, 0, 0, 1, 32'h02000804, 6'd32, 0, 1, 0};
        tbl[19] = '{0, 1, 0, 16'h0000, 0, 0, 0, 1, 32'h02000804, 6'd32, 0, 0, 1};
        tbl[20] = '{0, 1, 0, 16'h0000, 0, 0, 1, 1, 32'h020B3344, 6'd32, 0, 1, 0};
        tbl[21] = '{0, 1, 0, 16'h0000, 0, 0, 0, 1, 32'h020B3344, 6'd32, 0, 1, 0};
        tbl[22] = '{0, 1, 0, 16'h0000, 0, 1, 0, 1, 32'h020B3344, 6'd32, 0, 0, 0};
        tbl[23] = '{1, 1, 0, 16'h0000, 0, 0, 0, 0, 32'h00000000, 6'd0,  0, 0, 0};

        for (int i = 0; i < NV; i++) begin
            RESET     = tbl[i].rst;
            DREQ      = tbl[i].dreq;
            VOL_REQ   = tbl[i].vreq;
            VOL_VALUE = tbl[i].vval;
            NEXT_REQ  = tbl[i].nreq;
            SPI_DONE  = tbl[i].done;
            step();
            chk($sformatf("vec%0d", i),
                {SPI_START, SPI_SCI, SPI_WORD, SPI_BITS, DATA_TAKE, BUSY, TRACK_NEXT},
                {tbl[i].start, tbl[i].sci, tbl[i].word, tbl[i].bits,
                 tbl[i].take, tbl[i].busy, tbl[i].trk});
        end

        // Full burst: DREQ dropped after the first byte must not cut it short.
        RESET = 1'b0; VOL_REQ = 1'b0; NEXT_REQ = 1'b0; SPI_DONE = 1'b0;
        sci_q.delete(); sdi_q.delete();
        takes = 0; sdi_starts = 0;
        auto_spi = 1'b1; sb_en = 1'b1; rd_en = 1'b1;
        rd_byte = 8'h00; DATA_BYTE = 8'h00; DATA_VALID = 1'b1;
        sdi_q.push_back(32'h0);
        DREQ = 1'b1;
        for (int c = 0; c < 20 && sdi_starts == 0; c++) step();
        DREQ = 1'b0;
        chk("a_first_start", sdi_starts, 1);
        repeat (250) step();
        chk("a_takes", takes, 32);
        chk("a_starts", sdi_starts, 32);
        DREQ = 1'b1;
        for (int c = 0; c < 20 && sdi_starts == 32; c++) step();
        chk("a_restart", sdi_starts, 33);

        // Pause after byte 10 of this burst; the burst still completes.
        for (int c = 0; c < 100 && takes < 42; c++) step();
        chk("b_byte10", takes, 42);
        s0 = sci_starts;
        IS_SUSPENDING = 1'b1;
        if (MUTE_N != 0) sci_q.push_back(32'h020BFEFE);
        repeat (250) step();
        chk("b_takes_paused", takes, 64);
        vol(16'h1234);
        repeat (20) step();
        chk("b_sci_paused", sci_starts - s0, 1 + MUTE_N);
        chk("b_no_take", takes, 64);

        // Resume, then change track at byte 5 of the next burst.
        DATA_VALID = 1'b0;
        IS_SUSPENDING = 1'b0;
        if (MUTE_N != 0) sci_q.push_back(32'h020B1234);
        repeat (10) step();
        DATA_VALID = 1'b1;
        t0 = takes;
        for (int c = 0; c < 100 && takes < t0 + 5; c++) step();
        chk("c_byte5", takes, t0 + 5);
        s0 = sci_starts;
        k0 = trk_cnt;
        NEXT_REQ = 1'b1;
        sci_q.push_back(32'h02000804);
        step();
        NEXT_REQ = 1'b0;
        for (int c = 0; c < 30 && sci_starts == s0; c++) step();
        chk("c_rst_issued", sci_starts - s0, 1);
        DREQ = 1'b0;
        chk("c_abandon", takes, t0 + 5);
        repeat (20) step();
        chk("c_trk_wait", trk_cnt - k0, 0);
        DREQ = 1'b1;
        repeat (3) step();
        chk("c_trk_once", trk_cnt - k0, 1);
        repeat (40) step();
        chk("c_resume", takes > t0 + 5, 1);
        chk("sci_q_drained", sci_q.size(), 0);

        // Reset while waiting on an SDI transfer, then a stray SPI_DONE.
        for (int c = 0; c < 20 && !DATA_TAKE; c++) step();
        chk("d_take_seen", DATA_TAKE, 1);
        step();
        sb_en = 1'b0; auto_spi = 1'b0; rd_en = 1'b0; timer = 0;
        SPI_DONE = 1'b0; DATA_VALID = 1'b0; RESET = 1'b1;
        step();
        chk("d_reset_outs",
            {SPI_START, SPI_SCI, SPI_WORD, SPI_BITS, DATA_TAKE, BUSY, TRACK_NEXT}, 0);
        RESET = 1'b0; SPI_DONE = 1'b1;
        step();
        SPI_DONE = 1'b0;
        chk("d_late_done", {SPI_START, DATA_TAKE, BUSY}, 0);
        repeat (3) step();
        chk("d_quiet", {SPI_START, DATA_TAKE, BUSY, TRACK_NEXT}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
